// File: rtl/ctrl_pkg.sv
// Shared encodings for the slice_ctrl control FSM and its instruction decoder.
package ctrl_pkg;

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

    typedef enum logic [3:0] {
        C_ILLEGAL, C_OP, C_OPIMM, C_LUI, C_AUIPC,
        C_JAL, C_JALR, C_BRANCH, C_LOAD, C_STORE
    } iclass_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] RD_ALU   = 3'b000;
    localparam logic [2:0] RD_SHIFT = 3'b001;
    localparam logic [2:0] RD_CMP   = 3'b010;
    localparam logic [2:0] RD_IMM   = 3'b011;
    localparam logic [2:0] RD_PCP4  = 3'b100;
    localparam logic [2:0] RD_MEM   = 3'b101;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_XOR = 2'b01;
    localparam logic [1:0] ALU_OR  = 2'b10;
    localparam logic [1:0] ALU_AND = 2'b11;

    // Datapath selects that depend only on the latched instruction.
    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_inv_rs2, alu_cin, alu_mux_1_sel, alu_mux_2_sel;
        logic       cmp_mux_sel, cmp_sign_flip;
        logic       shift_dir, shift_arith, shamt_sel, pc_lsb_clr;
        logic [2:0] rd_mux_sel;
    } dp_sel_t;

    function automatic logic [3:0] mask_base(input logic [1:0] size);
        case (size)
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/inst_decode.sv
// Combinational RV32I decoder: latched instruction -> immediate, one-hot
// register selects, instruction class and static datapath selects.
module inst_decode
    import ctrl_pkg::*;
(
    input  logic [31:0] ir,
    output iclass_t     iclass,
    output logic [2:0]  funct3,
    output logic [31:0] imm,
    output logic [31:0] rs1_sel,
    output logic [31:0] rs2_sel,
    output logic [31:0] rd_sel,
    output dp_sel_t     sel
);
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        use_rs1, use_rs2, use_rd, imm_form;

    assign funct3 = ir[14:12];
    assign imm_i  = {{20{ir[31]}}, ir[31:20]};
    assign imm_s  = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b  = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_u  = {ir[31:12], 12'b0};
    assign imm_j  = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
    assign imm_form = (ir[6:0] == OPC_OPIMM);

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        iclass  = C_ILLEGAL;
        imm     = '0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        sel     = '0;
        if (ir[1:0] == 2'b11) begin
            case (ir[6:0])
                OPC_OP, OPC_OPIMM: begin
                    iclass            = imm_form ? C_OPIMM : C_OP;
                    imm               = imm_form ? imm_i : '0;
                    use_rs1           = 1'b1;
                    use_rs2           = !imm_form;
                    use_rd            = 1'b1;
                    sel.alu_mux_2_sel = imm_form;
                    case (funct3)
                        3'b000: begin
                            sel.alu_inv_rs2 = !imm_form && ir[30];
                            sel.alu_cin     = !imm_form && ir[30];
                        end
                        3'b001: begin
                            sel.rd_mux_sel = RD_SHIFT;
                            sel.shamt_sel  = imm_form;
                        end
                        3'b010, 3'b011: begin
                            sel.rd_mux_sel    = RD_CMP;
                            sel.cmp_mux_sel   = imm_form;
                            sel.cmp_sign_flip = !funct3[0];
                        end
                        3'b100: sel.alu_op = ALU_XOR;
                        3'b101: begin
                            sel.rd_mux_sel  = RD_SHIFT;
                            sel.shift_dir   = 1'b1;
                            sel.shift_arith = ir[30];
                            sel.shamt_sel   = imm_form;
                        end
                        3'b110:  sel.alu_op = ALU_OR;
                        default: sel.alu_op = ALU_AND;
                    endcase
                end
                OPC_LUI: begin
                    iclass         = C_LUI;
                    imm            = imm_u;
                    use_rd         = 1'b1;
                    sel.rd_mux_sel = RD_IMM;
                end
                OPC_AUIPC, OPC_JAL: begin
                    iclass            = (ir[6:0] == OPC_JAL) ? C_JAL : C_AUIPC;
                    imm               = (ir[6:0] == OPC_JAL) ? imm_j : imm_u;
                    use_rd            = 1'b1;
                    sel.alu_mux_1_sel = 1'b1;
                    sel.alu_mux_2_sel = 1'b1;
                    sel.rd_mux_sel    = (ir[6:0] == OPC_JAL) ? RD_PCP4 : RD_ALU;
                end
                OPC_JALR: begin
                    iclass            = C_JALR;
                    imm               = imm_i;
                    use_rs1           = 1'b1;
                    use_rd            = 1'b1;
                    sel.alu_mux_2_sel = 1'b1;
                    sel.rd_mux_sel    = RD_PCP4;
                    sel.pc_lsb_clr    = 1'b1;
                end
                OPC_BRANCH: if (funct3[2:1] != 2'b01) begin
                    iclass            = C_BRANCH;
                    imm               = imm_b;
                    use_rs1           = 1'b1;
                    use_rs2           = 1'b1;
                    sel.alu_mux_1_sel = 1'b1;
                    sel.alu_mux_2_sel = 1'b1;
                    sel.cmp_sign_flip = (funct3[2:1] == 2'b10);
                end
                // Undefined access sizes are treated as illegal encodings.
                OPC_LOAD: if (funct3[1:0] != 2'b11 && funct3[2:1] != 2'b11) begin
                    iclass            = C_LOAD;
                    imm               = imm_i;
                    use_rs1           = 1'b1;
                    use_rd            = 1'b1;
                    sel.alu_mux_2_sel = 1'b1;
                end
                OPC_STORE: if (!funct3[2] && funct3[1:0] != 2'b11) begin
                    iclass            = C_STORE;
                    imm               = imm_s;
                    use_rs1           = 1'b1;
                    use_rs2           = 1'b1;
                    sel.alu_mux_2_sel = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign rs1_sel = use_rs1 ? (32'd1 << ir[19:15]) : '0;
    assign rs2_sel = use_rs2 ? (32'd1 << ir[24:20]) : '0;
    assign rd_sel  = (use_rd && ir[11:7] != 5'd0) ? (32'd1 << ir[11:7]) : '0;

endmodule

// File: rtl/slice_ctrl.sv
// Multi-cycle control FSM for the bit-sliced RV32I datapath: fetch, decode,
// memory handshake, branch resolution and retired-instruction counting.
module slice_ctrl
    import ctrl_pkg::*;
#(
    parameter bit CHECK_ALIGN = 1'b1,
    parameter int RET_CNT_W   = 32
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mem_resp,
    input  logic [31:0]          mem_rdata,
    input  logic [1:0]           addr_lo,
    input  logic                 cmp_eq,
    input  logic                 cmp_lt,
    output logic                 mem_addr_sel,
    output logic [3:0]           mem_rmask,
    output logic [3:0]           mem_wmask,
    output logic [31:0]          rs1_sel,
    output logic [31:0]          rs2_sel,
    output logic [31:0]          rd_sel,
    output logic [31:0]          imm,
    output logic [1:0]           alu_op,
    output logic                 alu_inv_rs2,
    output logic                 alu_cin,
    output logic                 alu_mux_1_sel,
    output logic                 alu_mux_2_sel,
    output logic                 cmp_mux_sel,
    output logic                 cmp_sign_flip,
    output logic                 shift_dir,
    output logic                 shift_arith,
    output logic                 shamt_sel,
    output logic [2:0]           rd_mux_sel,
    output logic [2:0]           mem_mux_sel,
    output logic                 pc_mux_sel,
    output logic                 pc_we,
    output logic                 pc_lsb_clr,
    output logic                 commit,
    output logic                 halt,
    output logic [RET_CNT_W-1:0] retired
);
    state_t      state;
    logic [31:0] ir;

    iclass_t     iclass;
    logic [2:0]  funct3;
    logic [31:0] dec_imm, dec_rs1_sel, dec_rs2_sel, dec_rd_sel;
    dp_sel_t     dec_sel, dp;

    inst_decode u_decode (
        .ir      (ir),
        .iclass  (iclass),
        .funct3  (funct3),
        .imm     (dec_imm),
        .rs1_sel (dec_rs1_sel),
        .rs2_sel (dec_rs2_sel),
        .rd_sel  (dec_rd_sel),
        .sel     (dec_sel)
    );

    logic       active, is_mem, is_load, misaligned, taken;
    logic [3:0] mask;

    assign active  = (state == S_EXEC) || (state == S_MEM);
    assign is_mem  = (iclass == C_LOAD) || (iclass == C_STORE);
    assign is_load = (iclass == C_LOAD);
    assign mask    = mask_base(funct3[1:0]) << addr_lo;
    assign misaligned = CHECK_ALIGN &&
                        (((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                         ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00)));
    // Signed/unsigned is handled by cmp_sign_flip; funct3[0] inverts the sense.
    assign taken   = (funct3[2] ? cmp_lt : cmp_eq) ^ funct3[0];
    assign dp      = active ? dec_sel : '0;

    always_comb begin
        mem_addr_sel  = 1'b0;
        mem_rmask     = '0;
        mem_wmask     = '0;
        rd_sel        = '0;
        mem_mux_sel   = '0;
        pc_mux_sel    = 1'b0;
        pc_we         = 1'b0;
        commit        = 1'b0;
        halt          = 1'b0;
        rs1_sel       = active ? dec_rs1_sel : '0;
        rs2_sel       = active ? dec_rs2_sel : '0;
        imm           = active ? dec_imm : '0;
        alu_op        = dp.alu_op;
        alu_inv_rs2   = dp.alu_inv_rs2;
        alu_cin       = dp.alu_cin;
        alu_mux_1_sel = dp.alu_mux_1_sel;
        alu_mux_2_sel = dp.alu_mux_2_sel;
        cmp_mux_sel   = dp.cmp_mux_sel;
        cmp_sign_flip = dp.cmp_sign_flip;
        shift_dir     = dp.shift_dir;
        shift_arith   = dp.shift_arith;
        shamt_sel     = dp.shamt_sel;
        pc_lsb_clr    = dp.pc_lsb_clr;
        rd_mux_sel    = dp.rd_mux_sel;
        case (state)
            S_FETCH: mem_rmask = 4'hF;
            S_EXEC: if (iclass != C_ILLEGAL && !is_mem) begin
                rd_sel     = dec_rd_sel;
                pc_we      = 1'b1;
                commit     = 1'b1;
                pc_mux_sel = (iclass == C_BRANCH) ? taken
                           : (iclass == C_JAL) || (iclass == C_JALR);
            end
            S_MEM: begin
                mem_addr_sel = 1'b1;
                if (is_load) begin
                    rd_mux_sel  = RD_MEM;
                    mem_mux_sel = funct3;
                end
                if (!misaligned) begin
                    mem_rmask = is_load ? mask : 4'h0;
                    mem_wmask = is_load ? 4'h0 : mask;
                    if (mem_resp) begin
                        rd_sel = is_load ? dec_rd_sel : '0;
                        pc_we  = 1'b1;
                        commit = 1'b1;
                    end
                end
            end
            default: halt = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_FETCH;
            ir      <= '0;
            retired <= '0;
        end else begin
            case (state)
                S_FETCH: if (mem_resp) begin
                    ir    <= mem_rdata;
                    state <= S_EXEC;
                end
                S_EXEC: state <= (iclass == C_ILLEGAL) ? S_HALT
                               : is_mem ? S_MEM : S_FETCH;
                S_MEM: begin
                    if (misaligned)    state <= S_HALT;
                    else if (mem_resp) state <= S_FETCH;
                end
                default: state <= S_HALT;
            endcase
            if (commit) retired <= retired + RET_CNT_W'(1);
        end
    end

endmodule
